// File: rtl/argmax_uint16_stream.sv
// Streaming argmax over a frame of unsigned words: tracks the running maximum and the
// index of its first occurrence, then presents the frame result on a valid/ready stream.

module gt_uint_nbit #(
    parameter int N         = 16,
    parameter int IMPL_TYPE = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gt
);
    generate
        if (IMPL_TYPE == 0) begin : g_behav
            assign gt = (a > b);
        end else begin : g_msb_scan
            logic decided;

            // NOTE: always_comb assigns every output first, so no path leaves gt or decided unassigned and no latch is inferred.
            always_comb begin
                gt      = 1'b0;
                decided = 1'b0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (!decided && (a[i] != b[i])) begin
                        gt      = a[i];
                        decided = 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

module argmax_uint16_stream #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_max,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_ovf
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           state_q,    state_d;
    logic [WIDTH-1:0]     max_q,      max_d;
    logic [IDX_WIDTH-1:0] idx_q,      idx_d;
    logic [IDX_WIDTH-1:0] cnt_q,      cnt_d;
    logic                 cnt_full_q, cnt_full_d;
    logic                 ovf_q,      ovf_d;
    logic [WIDTH-1:0]     out_max_q,  out_max_d;
    logic [IDX_WIDTH-1:0] out_idx_q,  out_idx_d;
    logic                 out_ovf_q,  out_ovf_d;

    logic in_fire;
    logic in_gt;

    gt_uint_nbit #(
        .N         (WIDTH),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_gt (
        .a  (in_data),
        .b  (max_q),
        .gt (in_gt)
    );

    assign in_ready  = !rst && (state_q != S_DONE);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cnt_full_d = cnt_full_q;
        ovf_d      = ovf_q;
        out_max_d  = out_max_q;
        out_idx_d  = out_idx_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    max_d      = in_data;
                    idx_d      = '0;
                    cnt_d      = IDX_WIDTH'(1);
                    cnt_full_d = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire) begin
                    if (in_gt) begin
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
                    // cnt_full marks that index all-ones has been handed out; any further word overflows.
                    if (cnt_q == '1) begin
                        if (cnt_full_q) begin
                            ovf_d = 1'b1;
                        end
                        cnt_full_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_WIDTH'(1);
                    end
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result registers load only at frame end so they hold steady until the next frame closes.
        if (in_fire && in_last) begin
            out_max_d = max_d;
            out_idx_d = idx_d;
            out_ovf_d = ovf_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            max_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cnt_full_q <= 1'b0;
            ovf_q      <= 1'b0;
            out_max_q  <= '0;
            out_idx_q  <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cnt_full_q <= cnt_full_d;
            ovf_q      <= ovf_d;
            out_max_q  <= out_max_d;
            out_idx_q  <= out_idx_d;
            out_ovf_q  <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_argmax_uint16_stream.sv
// Bench for argmax_uint16_stream: two instances (IDX_WIDTH 8 and 2) share one input stream;
// a reference model pushes expected results per frame and a monitor pops them on output handshakes.

module tb_argmax_uint16_stream;
    typedef struct packed {
        logic [15:0] max;
        logic [7:0]  idx;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_max;
    logic [7:0]  out_idx;

    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [15:0] s_out_max;
    logic [1:0]  s_out_idx;

    int n_compared = 0;
    int n_failed   = 0;

    logic [15:0] frame[$];
    exp_t        exp_big_q[$];
    exp_t        exp_small_q[$];

    always #5 clk = ~clk;

    argmax_uint16_stream #(.WIDTH(16), .IDX_WIDTH(8), .IMPL_TYPE(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_idx(out_idx), .out_ovf(out_ovf)
    );

    argmax_uint16_stream #(.WIDTH(16), .IDX_WIDTH(2), .IMPL_TYPE(1)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_max(s_out_max), .out_idx(s_out_idx), .out_ovf(s_out_ovf)
    );

    function automatic exp_t model(input int w);
        exp_t e;
        int   pos;
        int   lim;
        logic [15:0] m;
        m   = frame[0];
        pos = 0;
        for (int i = 1; i < frame.size(); i++) begin
            if (frame[i] > m) begin
                m   = frame[i];
                pos = i;
            end
        end
        lim   = (1 << w) - 1;
        e.max = m;
        e.idx = 8'((pos > lim) ? lim : pos);
        e.ovf = (frame.size() > (1 << w));
        return e;
    endfunction

    // Scoreboard monitor: compares on every cycle that will complete an output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            n_compared++;
            if (exp_big_q.size() == 0) begin
                n_failed++;
                $display("FAIL result_big: unexpected result max=%h idx=%0d ovf=%0d, none expected",
                         out_max, out_idx, out_ovf);
            end else begin
                e = exp_big_q.pop_front();
                if ({out_max, out_idx, out_ovf} !== {e.max, e.idx, e.ovf}) begin
                    n_failed++;
                    $display("FAIL result_big: got max=%h idx=%0d ovf=%0d, want max=%h idx=%0d ovf=%0d",
                             out_max, out_idx, out_ovf, e.max, e.idx, e.ovf);
                end
            end
            n_compared++;
            if (exp_small_q.size() == 0 || !s_out_valid) begin
                n_failed++;
                $display("FAIL result_small: out_valid=%0d with %0d expected results queued",
                         s_out_valid, exp_small_q.size());
            end else begin
                e = exp_small_q.pop_front();
                if ({s_out_max, 6'b0, s_out_idx, s_out_ovf} !== {e.max, e.idx, e.ovf}) begin
                    n_failed++;
                    $display("FAIL result_small: got max=%h idx=%0d ovf=%0d, want max=%h idx=%0d ovf=%0d",
                             s_out_max, s_out_idx, s_out_ovf, e.max, e.idx, e.ovf);
                end
            end
        end
    end

    // Drives the current frame; returns on the falling edge after the last word is accepted.
    task automatic send_frame();
        exp_big_q.push_back(model(8));
        exp_small_q.push_back(model(2));
        for (int i = 0; i < frame.size(); i++) begin
            int n;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame[i];
            in_last  = (i == frame.size() - 1);
            n = 0;
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                n_compared++;
                n_failed++;
                $display("FAIL in_ready_timeout: in_ready=%0d after %0d cycles, want 1", in_ready, n);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_big_q.size() != 0 || exp_small_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_compared++;
        if (exp_big_q.size() != 0 || exp_small_q.size() != 0) begin
            n_failed++;
            $display("FAIL drain: %0d/%0d results outstanding, want 0/0", exp_big_q.size(), exp_small_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        repeat (3) @(negedge clk);
        n_compared++;
        if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
            n_failed++;
            $display("FAIL reset_in_ready: got %0d/%0d, want 0/0", in_ready, s_in_ready);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({out_valid, out_max, out_idx, out_ovf} !== 26'd0) begin
            n_failed++;
            $display("FAIL reset_outputs: got valid=%0d max=%h idx=%0d ovf=%0d, want all 0",
                     out_valid, out_max, out_idx, out_ovf);
        end
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_failed++;
            $display("FAIL reset_release_in_ready: got %0d, want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        frame = '{16'd3, 16'd9, 16'd9, 16'd2};
        send_frame();
        n_compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_failed++;
            $display("FAIL basic_latency: got out_valid=%0d in_ready=%0d, want 1/0", out_valid, in_ready);
        end
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_failed++;
            $display("FAIL basic_after_handshake: got out_valid=%0d in_ready=%0d, want 0/1", out_valid, in_ready);
        end
        wait_drain();
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        frame = '{16'h1234};
        send_frame();
        n_compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 16'h1234 || out_idx !== 8'd0) begin
            n_failed++;
            $display("FAIL single_word: got valid=%0d in_ready=%0d max=%h idx=%0d, want 1/0/1234/0",
                     out_valid, in_ready, out_max, out_idx);
        end
        wait_drain();
    endtask

    task automatic test_unsigned();
        out_ready = 1'b1;
        frame = '{16'h7FFF, 16'hFFFF, 16'h8000};
        send_frame();
        wait_drain();
        frame = '{16'd4, 16'd4, 16'd4};
        send_frame();
        wait_drain();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        frame = '{16'd5, 16'd6};
        send_frame();
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 16'd6 || out_idx !== 8'd1 || out_ovf !== 1'b0) begin
                n_failed++;
                $display("FAIL hold_stable: got valid=%0d in_ready=%0d max=%h idx=%0d ovf=%0d, want 1/0/0006/1/0",
                         out_valid, in_ready, out_max, out_idx, out_ovf);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        frame = '{16'hAAAA};
        send_frame();
        wait_drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        frame = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd9};
        send_frame();
        wait_drain();
        frame = '{16'd5};
        send_frame();
        wait_drain();
        frame = '{16'd1, 16'd1, 16'd1, 16'd8};
        send_frame();
        wait_drain();
        frame.delete();
        for (int i = 0; i < 300; i++) begin
            frame.push_back(16'($urandom_range(0, 16'hFF00)));
        end
        frame[100] = 16'hFFFE;
        frame[280] = 16'hFFFF;
        send_frame();
        wait_drain();
    endtask

    task automatic test_mid_frame_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd7;
        @(negedge clk);
        in_data  = 16'd8;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({out_valid, out_max, out_idx, out_ovf} !== 26'd0) begin
            n_failed++;
            $display("FAIL mid_reset_outputs: got valid=%0d max=%h idx=%0d ovf=%0d, want all 0",
                     out_valid, out_max, out_idx, out_ovf);
        end
        frame = '{16'd4};
        send_frame();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(1, 7);
            frame.delete();
            for (int i = 0; i < len; i++) begin
                frame.push_back(16'($urandom_range(0, 7)));
            end
            send_frame();
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_word();
        test_unsigned();
        test_hold();
        test_overflow();
        test_mid_frame_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule

// File: doc/argmax_uint16_stream.md
Name: argmax_uint16_stream

Overview:
- Streaming reduction stage directly downstream of the 16-bit unsigned greater-than comparator (gt_uint_nbit).
- Accepts a frame of unsigned words over a valid/ready input stream and tracks the running maximum and its position. Every "new > current" decision is made by one gt_uint_nbit instance.
- At frame end, presents the maximum value and its index on a valid/ready output stream.
- Serves as the benchmark-level sequential consumer of the comparator in the pimsynth flow.

Parameters:
- WIDTH, 16, data word width; unsigned.
- IDX_WIDTH, 8, width of the element index and counter.
- IMPL_TYPE, 0, passed unchanged to the internal gt_uint_nbit instance.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  unsigned input word.
- in_last  input  1  marks final word of the frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_max  output  WIDTH  maximum value of the frame.
- out_idx  output  IDX_WIDTH  zero-based index of the first occurrence of the maximum.
- out_ovf  output  1  frame had more than 2^IDX_WIDTH words.

Behaviour:
- Reset:
  - State goes to IDLE.
  - out_valid=0, out_max=0, out_idx=0, out_ovf=0.
  - Internal max/idx/counter/ovf cleared.
  - in_ready=0 while rst is high.
  - Any partial frame or held result is discarded.
- Input transfer occurs on a cycle with in_valid & in_ready. Output transfer occurs on a cycle with out_valid & out_ready.
- State machine:
  - IDLE: in_ready=1; no words of the current frame yet.
    - On transfer: max<=in_data, idx<=0, cnt<=1, ovf<=0.
    - If in_last: go to DONE, else go to ACCUM.
  - ACCUM: in_ready=1.
    - On transfer: if gt(in_data, max) then max<=in_data and idx<=cnt.
    - Then cnt<=cnt+1, saturating at all-ones. Once cnt is all-ones and another word arrives, ovf<=1.
    - If in_last: go to DONE.
  - DONE: in_ready=0; out_valid=1; out_max/out_idx/out_ovf hold the registered results.
    - On output transfer: go to IDLE and drop out_valid.
- Comparison is strictly greater-than and unsigned. On ties the earlier index is kept.
- Latency: out_valid rises the cycle after the in_last word is accepted, and the result includes that word.
- Outputs are stable while out_valid=1 and out_ready=0.
- Frames are separated by at least one idle input cycle: in_ready is low in DONE and returns high the cycle after the output handshake.
- in_data/in_last are ignored when no transfer occurs.
- Index overflow (frame longer than 2^IDX_WIDTH words):
  - Comparison continues for every word.
  - A winning word past the limit records idx = all-ones (saturated cnt).
  - out_ovf=1 for that frame.
- out_max/out_idx/out_ovf retain their last values outside DONE; only out_valid qualifies them.
- All outputs are registered or derived from state only. There is no combinational path from in_* to out_*.

Test Plan:
- Frame [3, 9, 9, 2], last on 2, out_ready=1 -> out_valid one cycle after the last accept; out_max=9, out_idx=1, out_ovf=0; in_ready=1 again the cycle after the handshake.
- Single-word frame 0x1234 with in_last -> next cycle out_max=0x1234, out_idx=0; in_ready=0 while out_valid is high.
- Frame [0x7FFF, 0xFFFF, 0x8000] -> out_max=0xFFFF, out_idx=1 (confirms unsigned, not signed, compare).
- Result held with out_ready=0 for 5 cycles, in_valid=1 throughout -> out_* unchanged, in_ready=0, no word consumed; next frame starts after out_ready pulse.
- IDX_WIDTH=2, frame [1, 2, 3, 4, 5, 9] -> out_max=9, out_idx=3, out_ovf=1; a following frame [5] gives out_ovf=0, out_idx=0.
- rst pulsed after 2 words of frame [7, 8, ...] -> out_valid=0, outputs 0; new frame [4] gives out_max=4, out_idx=0 (no stale max 8).
